// File: rtl/song_sequencer_if.sv
// song_sequencer_if: control pulses in, registered note stream and status out.
interface song_sequencer_if;
    logic       play;
    logic       pause;
    logic       stop;
    logic [4:0] note;
    logic [5:0] step_idx;
    logic       playing;
    logic       paused;
    logic       done;
    modport master(output play, pause, stop, input note, step_idx, playing, paused, done);
    modport slave(input play, pause, stop, output note, step_idx, playing, paused, done);
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer: steps a fixed 30-note melody ROM at a fixed tempo with play/pause/stop,
// end-of-song done pulse, optional looping and a re-attack gap between equal notes.
module song_sequencer #(
    parameter int TICK_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 2000000,
    parameter bit LOOP        = 1'b0
) (
    input logic clk,
    input logic rst,
    song_sequencer_if.slave bus
);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0] T_GAP  = TW'(TICK_CYCLES - GAP_CYCLES);
    typedef enum logic [1:0] {IDLE, PLAY, PAUSED} state_t;
    state_t state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [4:0] idx, idx_n, note_n;
    logic done_n, wrap, last;
    function automatic logic [4:0] rom(input logic [4:0] a);
        case (a)
            5'd0, 5'd1, 5'd2, 5'd16, 5'd17, 5'd18:               rom = 5'd7;
            5'd3, 5'd8, 5'd9, 5'd15, 5'd19, 5'd24, 5'd25:        rom = 5'd8;
            5'd4, 5'd5, 5'd7, 5'd14, 5'd20, 5'd21, 5'd23:        rom = 5'd9;
            5'd6, 5'd12, 5'd13, 5'd22:                           rom = 5'd10;
            5'd10, 5'd11, 5'd26, 5'd27, 5'd28, 5'd29:            rom = 5'd6;
            default:                                             rom = 5'd31;
        endcase
    endfunction
    // Silence the tail of a step when the next step repeats the same pitch.
    function automatic logic [4:0] note_for(input logic [4:0] a, input logic [TW-1:0] t);
        logic [4:0] c, nx;
        c  = rom(a);
        nx = rom(a + 5'd1);
        note_for = (c != 5'd0 && c != 5'd31 && nx == c && t >= T_GAP) ? 5'd0 : c;
    endfunction
    assign wrap = tcnt == T_LAST;
    assign last = rom(idx + 5'd1) == 5'd31;
    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        idx_n   = idx;
        done_n  = 1'b0;
        if (bus.stop) begin
            state_n = IDLE;
            tcnt_n  = '0;
            idx_n   = '0;
        end else if (state == IDLE) begin
            state_n = bus.play ? PLAY : IDLE;
            tcnt_n  = '0;
            idx_n   = '0;
        end else if (state == PLAY) begin
            tcnt_n  = wrap ? '0 : tcnt + 1'b1;
            idx_n   = !wrap ? idx : last ? 5'd0 : idx + 5'd1;
            state_n = bus.pause ? PAUSED : PLAY;
            if (wrap && last && !LOOP) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end else begin
            state_n = (bus.pause || bus.play) ? PLAY : PAUSED;
        end
        note_n = state_n == PLAY ? note_for(idx_n, tcnt_n) : 5'd0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            idx         <= '0;
            bus.note    <= '0;
            bus.playing <= 1'b0;
            bus.paused  <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            state       <= state_n;
            tcnt        <= tcnt_n;
            idx         <= idx_n;
            bus.note    <= note_n;
            bus.playing <= state_n == PLAY;
            bus.paused  <= state_n == PAUSED;
            bus.done    <= done_n;
        end
    end
    assign bus.step_idx = {1'b0, idx};
endmodule
